mc_alu: RTL and testbench



---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_muldiv_iter.sv | 78 +++++++
 rtl/mc_alu.sv | 129 ++++++++++++
 tb/tb_mc_alu.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode and FSM state encodings for the multi-cycle ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_XOR  = 4'b0011,
    OP_SUB  = 4'b0100,
    OP_MUL  = 4'b0101,
    OP_SLT  = 4'b0110,
    OP_SLTU = 4'b0111,
    OP_DIVU = 4'b1000,
    OP_SLL  = 4'b1001,
    OP_SRL  = 4'b1010,
    OP_SRA  = 4'b1011,
    OP_NOR  = 4'b1100
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// One-bit-per-cycle shift-add multiplier / restoring divider sharing one {hi,lo} register pair.
// The divide path is only built when ALU_DIV_EN is defined.
module alu_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             en,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  logic [WIDTH-1:0] hi_q, lo_q, m_q;
  logic [WIDTH-1:0] hi_d, lo_d;
  logic [WIDTH:0]   sum;

  // Multiply: lo starts as the multiplier and is shifted out while the product shifts in.
  assign sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);

`ifdef ALU_DIV_EN
  logic             div_q;
  logic [WIDTH:0]   rem_sh;
  logic             ge;

  assign rem_sh = {hi_q, lo_q[WIDTH-1]};
  assign ge     = (rem_sh >= {1'b0, m_q});

  always_comb begin
    hi_d = sum[WIDTH:1];
    lo_d = {sum[0], lo_q[WIDTH-1:1]};
    if (div_q) begin
      hi_d = ge ? WIDTH'(rem_sh - {1'b0, m_q}) : rem_sh[WIDTH-1:0];
      lo_d = {lo_q[WIDTH-2:0], ge};
    end
  end
`else
  logic unused_div;
  assign unused_div = is_div;

  always_comb begin
    hi_d = sum[WIDTH:1];
    lo_d = {sum[0], lo_q[WIDTH-1:1]};
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
      m_q  <= '0;
`ifdef ALU_DIV_EN
      div_q <= 1'b0;
`endif
    end else if (start) begin
      hi_q <= '0;
`ifdef ALU_DIV_EN
      div_q <= is_div;
      lo_q  <= is_div ? a : b;
      m_q   <= is_div ? b : a;
`else
      lo_q  <= b;
      m_q   <= a;
`endif
    end else if (en) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  // Exposes the value after this cycle's step so the caller can register it on the last step.
  assign lo = lo_d;
  assign hi = hi_d;

endmodule

// File: rtl/mc_alu.sv
// Multi-cycle MIPS ALU: handshake, FSM, single-cycle ops and registered outputs.
// Define ALU_DIV_EN to build the iterative unsigned divider (opcode 1000).
module mc_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             div_by_zero
);

  localparam int SHW = $clog2(WIDTH);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] res_q, hi_q;
  logic             zero_q, dbz_q;

  op_t              op_c;
  logic [WIDTH-1:0] res_d, hi_d, it_lo, it_hi;
  logic             dbz_d, is_mul, is_div, hs, it_en;

  assign op_c   = op_t'(op);
  assign hs     = in_valid && (state_q == S_IDLE);
  assign is_mul = (op_c == OP_MUL);
`ifdef ALU_DIV_EN
  assign is_div = (op_c == OP_DIVU) && (b != '0);
`else
  assign is_div = 1'b0;
`endif
  assign it_en  = (state_q == S_MUL) || (state_q == S_DIV);

  always_comb begin
    res_d = a + b;
    hi_d  = '0;
    dbz_d = 1'b0;
    case (op_c)
      OP_AND:  res_d = a & b;
      OP_OR:   res_d = a | b;
      OP_XOR:  res_d = a ^ b;
      OP_SUB:  res_d = a - b;
      OP_SLT:  res_d = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: res_d = {{(WIDTH-1){1'b0}}, a < b};
      OP_SLL:  res_d = a << b[SHW-1:0];
      OP_SRL:  res_d = a >> b[SHW-1:0];
      OP_SRA:  res_d = $signed(a) >>> b[SHW-1:0];
      OP_NOR:  res_d = ~(a | b);
`ifdef ALU_DIV_EN
      // Divide by zero short-circuits the iteration; b != 0 goes to the iterator instead.
      OP_DIVU: if (b == '0) begin
        res_d = '1;
        hi_d  = a;
        dbz_d = 1'b1;
      end
`endif
      default: res_d = a + b;
    endcase
  end

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (hs),
    .en     (it_en),
    .is_div (is_div),
    .a      (a),
    .b      (b),
    .lo     (it_lo),
    .hi     (it_hi)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      hi_q    <= '0;
      zero_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          if (is_mul || is_div) begin
            state_q <= is_mul ? S_MUL : S_DIV;
            cnt_q   <= CNT_W'(WIDTH);
          end else begin
            state_q <= S_DONE;
            res_q   <= res_d;
            hi_q    <= hi_d;
            zero_q  <= (res_d == '0);
            dbz_q   <= dbz_d;
          end
        end
        S_MUL, S_DIV: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_q <= S_DONE;
            res_q   <= it_lo;
            hi_q    <= it_hi;
            zero_q  <= (it_lo == '0);
            dbz_q   <= 1'b0;
          end
        end
        S_DONE:  if (out_ready) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign result      = res_q;
  assign hi          = hi_q;
  assign zero        = zero_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mc_alu.sv
// Scoreboard bench for mc_alu: driver pushes expected results, monitor pops on each drained output.
module tb_mc_alu;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready, zero, div_by_zero;
  logic [W-1:0] a, b, result, hi;
  logic [3:0]   op;

  always #5 clk = ~clk;

  mc_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .hi(hi), .zero(zero), .div_by_zero(div_by_zero)
  );

  typedef struct {
    string        name;
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         z;
    logic         dbz;
    int           lat;
    int           issue;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: latency measured to the first out_valid cycle, outputs must hold until drained.
  initial begin : monitor
    logic         seen;
    int           first;
    logic [W-1:0] s_res, s_hi;
    logic         s_z, s_d;
    exp_t         e;
    seen = 1'b0;
    first = 0;
    forever begin
      @(negedge clk);
      if (rst) seen = 1'b0;
      else if (out_valid) begin
        chk("ready_valid_exclusive", in_ready, 1'b0);
        if (!seen) begin
          seen = 1'b1; first = cyc;
          s_res = result; s_hi = hi; s_z = zero; s_d = div_by_zero;
        end else begin
          chk("hold_result", result, s_res);
          chk("hold_hi", hi, s_hi);
          chk("hold_flags", {zero, div_by_zero}, {s_z, s_d});
        end
        if (out_ready) begin
          if (sbq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_output: result 0x%0h with nothing pending", result);
          end else begin
            e = sbq.pop_front();
            chk({e.name, "_result"}, result, e.res);
            chk({e.name, "_hi"}, hi, e.hi);
            chk({e.name, "_zero"}, zero, e.z);
            chk({e.name, "_dbz"}, div_by_zero, e.dbz);
            chk({e.name, "_latency"}, 64'(first - e.issue), 64'(e.lat));
          end
          seen = 1'b0;
        end
      end
    end
  end

  // Called and returns just after a rising edge.
  task automatic issue(input string name, input logic [3:0] o, input logic [W-1:0] ia, ib,
                       input logic [W-1:0] er, eh, input logic ez, ed, input int lat);
    exp_t e;
    int   n;
    n = 0;
    while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL %s_accept: in_ready stayed low", name);
      return;
    end
    in_valid = 1'b1; op = o; a = ia; b = ib;
    e.name = name; e.res = er; e.hi = eh; e.z = ez; e.dbz = ed; e.lat = lat; e.issue = cyc;
    sbq.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; op = 4'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
    chk("drain_pending", 64'(sbq.size()), 64'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1);
  end

  initial begin : stim
    int bad;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_result", result, '0);
    chk("rst_hi", hi, '0);
    chk("rst_flags", {zero, div_by_zero}, 2'b00);

    issue("sub_eq", 4'b0100, 5, 5, 0, 0, 1, 0, 1);
    issue("mul_max", 4'b0101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFE, 0, 0, W + 1);
    bad = 0;
    repeat (31) begin
      if (in_ready) bad++;
      @(posedge clk); #1;
    end
    chk("mul_busy_in_ready", 64'(bad), 64'd0);
    issue("mul_zero", 4'b0101, 32'h1_0000, 32'h1_0000, 32'h0, 32'h1, 1, 0, W + 1);
`ifdef ALU_DIV_EN
    issue("divu", 4'b1000, 100, 7, 14, 2, 0, 0, W + 1);
    issue("divu_by0", 4'b1000, 100, 0, 32'hFFFF_FFFF, 100, 0, 1, 1);
    issue("divu_small", 4'b1000, 7, 100, 0, 7, 1, 0, W + 1);
`else
    issue("divu_as_add", 4'b1000, 100, 7, 107, 0, 0, 0, 1);
    issue("divu_by0_add", 4'b1000, 100, 0, 100, 0, 0, 0, 1);
    issue("divu_small_add", 4'b1000, 7, 100, 107, 0, 0, 0, 1);
`endif
    issue("slt", 4'b0110, 32'hFFFF_FFFF, 1, 1, 0, 0, 0, 1);
    issue("sltu", 4'b0111, 32'hFFFF_FFFF, 1, 0, 0, 1, 0, 1);
    issue("sra", 4'b1011, 32'h8000_0000, 4, 32'hF800_0000, 0, 0, 0, 1);
    issue("and", 4'b0000, 32'hF0F0, 32'hFF00, 32'hF000, 0, 0, 0, 1);
    issue("or", 4'b0001, 32'hF0F0, 32'hFF00, 32'hFFF0, 0, 0, 0, 1);
    issue("xor", 4'b0011, 32'hF0F0, 32'hFF00, 32'h0FF0, 0, 0, 0, 1);
    issue("nor", 4'b1100, 0, 0, 32'hFFFF_FFFF, 0, 0, 0, 1);
    issue("sll", 4'b1001, 1, 31, 32'h8000_0000, 0, 0, 0, 1);
    issue("srl_mask", 4'b1010, 32'h8000_0000, 35, 32'h1000_0000, 0, 0, 0, 1);
    issue("add_wrap", 4'b0010, 32'hFFFF_FFFF, 1, 0, 0, 1, 0, 1);
    issue("sub_wrap", 4'b0100, 0, 1, 32'hFFFF_FFFF, 0, 0, 0, 1);
    issue("op_1101", 4'b1101, 2, 3, 5, 0, 0, 0, 1);
    drain();

    out_ready = 1'b0;
    issue("add_bp", 4'b0010, 3, 4, 7, 0, 0, 0, 1);
    bad = 0;
    repeat (5) begin
      if (in_ready || !out_valid) bad++;
      @(posedge clk); #1;
    end
    chk("bp_stall_state", 64'(bad), 64'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_in_ready_back", in_ready, 1'b1);
    chk("bp_out_valid_drop", out_valid, 1'b0);
    out_ready = 1'b1;
    drain();

    issue("mul_aborted", 4'b0101, 6, 7, 42, 0, 0, 0, W + 1);
    repeat (8) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sbq.delete();
    chk("abort_in_ready", in_ready, 1'b1);
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_result", result, '0);
    chk("abort_hi", hi, '0);
    issue("add_after_rst", 4'b0010, 1, 1, 2, 0, 0, 0, 1);
    drain();

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
